// File: rtl/agmv_pkg.sv
// Shared opcodes, FSM states, flag indices, ALU selects and the control word
// for the AGM-V 8-bit multi-cycle core.
package agmv_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDI = 8'h01;
  localparam logic [7:0] OP_MOV = 8'h02;
  localparam logic [7:0] OP_ADD = 8'h03;
  localparam logic [7:0] OP_SUB = 8'h04;
  localparam logic [7:0] OP_AND = 8'h05;
  localparam logic [7:0] OP_OR  = 8'h06;
  localparam logic [7:0] OP_XOR = 8'h07;
  localparam logic [7:0] OP_CMP = 8'h08;
  localparam logic [7:0] OP_LD  = 8'h09;
  localparam logic [7:0] OP_ST  = 8'h0A;
  localparam logic [7:0] OP_JMP = 8'h0B;
  localparam logic [7:0] OP_JEQ = 8'h0C;
  localparam logic [7:0] OP_JNE = 8'h0D;
  localparam logic [7:0] OP_JLT = 8'h0E;
  localparam logic [7:0] OP_JGT = 8'h0F;
  localparam logic [7:0] OP_HLT = 8'hFF;

  localparam int FLG_Z  = 0;
  localparam int FLG_C  = 1;
  localparam int FLG_N  = 2;
  localparam int FLG_V  = 3;
  localparam int FLG_LT = 4;
  localparam int FLG_EQ = 5;
  localparam int FLG_GT = 6;

  typedef enum logic [2:0] {
    FETCH_OP = 3'd0,
    FETCH_A  = 3'd1,
    FETCH_B  = 3'd2,
    EXEC     = 3'd3,
    HALT     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_PASS = 3'd5
  } alu_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_IMM = 2'd1,
    WB_RAM = 2'd2
  } wb_sel_t;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] op1;
    logic [7:0] op2;
  } ir_t;

  typedef struct packed {
    logic     pc_inc;
    logic     pc_load;
    logic     mar_load;
    logic     ir_ld_op;
    logic     ir_ld_a;
    logic     ir_ld_b;
    logic     mem_op;     // RAM address from op2 instead of PC
    logic     ram_we;
    logic     reg_we;
    wb_sel_t  wb_sel;
    logic     flg_arith;
    logic     flg_cmp;
    alu_sel_t alu_sel;
  } ctrl_t;

endpackage

// File: rtl/agmv_alu.sv
// 8-bit ALU: arithmetic/logic result with Z/C/N/V and an unsigned compare.
module agmv_alu
  import agmv_pkg::*;
(
  input  logic [7:0] operand1,
  input  logic [7:0] operand2,
  input  alu_sel_t   alu_sel,
  output logic [7:0] result,
  output logic       z,
  output logic       c,
  output logic       n,
  output logic       v,
  output logic [2:0] compare_result
);

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (alu_sel)
      ALU_ADD: begin
        {c, result} = {1'b0, operand1} + {1'b0, operand2};
        v = (operand1[7] == operand2[7]) && (result[7] != operand1[7]);
      end
      ALU_SUB: begin
        // bit 8 of the 9-bit difference is the borrow
        {c, result} = {1'b0, operand1} - {1'b0, operand2};
        v = (operand1[7] != operand2[7]) && (result[7] != operand1[7]);
      end
      ALU_AND:  result = operand1 & operand2;
      ALU_OR:   result = operand1 | operand2;
      ALU_XOR:  result = operand1 ^ operand2;
      ALU_PASS: result = operand2;
      default:  result = '0;
    endcase
    z = (result == 8'h00);
    n = result[7];
    compare_result = {operand1 > operand2, operand1 == operand2, operand1 < operand2};
  end

endmodule

// File: rtl/agmv_processor.sv
// AGM-V core: 3-byte instructions fetched from a unified 256x8 RAM, executed
// on an 8x8 register file in a 4-cycle FETCH_OP/FETCH_A/FETCH_B/EXEC loop.
module agmv_processor
  import agmv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic       halted,
  output logic [7:0] pc
);

  state_t     state, state_nx;
  ctrl_t      ctrl;
  ir_t        ir;
  logic [7:0] mar;
  logic [6:0] flags;
  logic [7:0] ram_addr, ram_rdata, ra_data, rb_data, wb_data;
  logic [7:0] alu_res;
  logic       alu_z, alu_c, alu_n, alu_v;
  logic [2:0] alu_cmp;
  logic       unused_mar;

  assign unused_mar = &{1'b0, mar};
  assign halted     = (state == HALT);
  assign ram_addr   = ctrl.mem_op ? ir.op2 : pc;

  if (1) begin : RandomAcessMemory
    logic [7:0] mem [256];

    assign ram_rdata = mem[ram_addr];

    always_ff @(posedge clk)
      if (ctrl.ram_we) mem[ram_addr] <= ra_data;

    task automatic init_memory(input logic [7:0] addr, input logic [7:0] data);
      mem[addr] <= data;
    endtask
  end

  if (1) begin : registers
    logic [7:0] rf [8];

    // both read ports sample pre-edge values, so ADD A,A sees the old A
    assign ra_data = rf[ir.op1[2:0]];
    assign rb_data = rf[ir.op2[2:0]];

    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        for (int i = 0; i < 8; i++) rf[i] <= '0;
      end else if (ctrl.reg_we) begin
        rf[ir.op1[2:0]] <= wb_data;
      end

    function automatic logic [7:0] read_memory(input logic [7:0] addr);
      logic [4:0] unused_hi;
      unused_hi = addr[7:3];
      return rf[addr[2:0]];
    endfunction
  end

  agmv_alu u_alu (
    .operand1      (ra_data),
    .operand2      (rb_data),
    .alu_sel       (ctrl.alu_sel),
    .result        (alu_res),
    .z             (alu_z),
    .c             (alu_c),
    .n             (alu_n),
    .v             (alu_v),
    .compare_result(alu_cmp)
  );

  always_comb begin
    case (ctrl.wb_sel)
      WB_IMM:  wb_data = ir.op2;
      WB_RAM:  wb_data = ram_rdata;
      default: wb_data = alu_res;
    endcase
  end

  // control unit: state + IR -> control word and next state
  always_comb begin
    ctrl     = '0;
    state_nx = state;
    case (state)
      FETCH_OP: begin
        ctrl.mar_load = 1'b1;
        ctrl.ir_ld_op = 1'b1;
        ctrl.pc_inc   = 1'b1;
        state_nx      = FETCH_A;
      end
      FETCH_A: begin
        ctrl.ir_ld_a = 1'b1;
        ctrl.pc_inc  = 1'b1;
        state_nx     = FETCH_B;
      end
      FETCH_B: begin
        ctrl.ir_ld_b = 1'b1;
        ctrl.pc_inc  = 1'b1;
        state_nx     = EXEC;
      end
      EXEC: begin
        state_nx = FETCH_OP;
        case (ir.opcode)
          OP_LDI: begin ctrl.reg_we = 1'b1; ctrl.wb_sel = WB_IMM; end
          OP_MOV: begin ctrl.reg_we = 1'b1; ctrl.alu_sel = ALU_PASS; end
          OP_ADD: begin ctrl.reg_we = 1'b1; ctrl.alu_sel = ALU_ADD; ctrl.flg_arith = 1'b1; end
          OP_SUB: begin ctrl.reg_we = 1'b1; ctrl.alu_sel = ALU_SUB; ctrl.flg_arith = 1'b1; end
          OP_AND: begin ctrl.reg_we = 1'b1; ctrl.alu_sel = ALU_AND; ctrl.flg_arith = 1'b1; end
          OP_OR:  begin ctrl.reg_we = 1'b1; ctrl.alu_sel = ALU_OR;  ctrl.flg_arith = 1'b1; end
          OP_XOR: begin ctrl.reg_we = 1'b1; ctrl.alu_sel = ALU_XOR; ctrl.flg_arith = 1'b1; end
          OP_CMP: ctrl.flg_cmp = 1'b1;
          OP_LD:  begin ctrl.reg_we = 1'b1; ctrl.wb_sel = WB_RAM; ctrl.mem_op = 1'b1; end
          OP_ST:  begin ctrl.ram_we = 1'b1; ctrl.mem_op = 1'b1; end
          OP_JMP: ctrl.pc_load = 1'b1;
          OP_JEQ: ctrl.pc_load = flags[FLG_EQ];
          OP_JNE: ctrl.pc_load = !flags[FLG_EQ];
          OP_JLT: ctrl.pc_load = flags[FLG_LT];
          OP_JGT: ctrl.pc_load = flags[FLG_GT];
          OP_HLT: state_nx = HALT;
          default: ;
        endcase
      end
      HALT:    state_nx = HALT;
      default: state_nx = FETCH_OP;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= FETCH_OP;
      pc    <= '0;
      mar   <= '0;
      ir    <= '0;
      flags <= '0;
    end else begin
      state <= state_nx;
      if (ctrl.pc_load)     pc <= ir.op1;
      else if (ctrl.pc_inc) pc <= pc + 8'd1;
      if (ctrl.mar_load) mar       <= pc;
      if (ctrl.ir_ld_op) ir.opcode <= ram_rdata;
      if (ctrl.ir_ld_a)  ir.op1    <= ram_rdata;
      if (ctrl.ir_ld_b)  ir.op2    <= ram_rdata;
      if (ctrl.flg_arith) flags[FLG_V:FLG_Z]  <= {alu_v, alu_n, alu_c, alu_z};
      if (ctrl.flg_cmp)   flags[FLG_GT:FLG_LT] <= alu_cmp;
    end

endmodule

// File: tb/tb_agmv_processor.sv
// Directed-program bench for agmv_processor; RAM is preloaded under reset and
// internal state is checked through the hierarchical test hooks.
module tb_agmv_processor;
  import agmv_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       halted;
  logic [7:0] pc;
  int         n_cmp = 0;
  int         n_err = 0;

  agmv_processor dut (
    .clk   (clk),
    .rst   (rst),
    .halted(halted),
    .pc    (pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // enter reset and wipe RAM to NOPs
  task automatic begin_load();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) dut.RandomAcessMemory.init_memory(8'(i), 8'h00);
  endtask

  task automatic ins(input logic [7:0] a, input logic [7:0] op,
                     input logic [7:0] o1, input logic [7:0] o2);
    dut.RandomAcessMemory.init_memory(a, op);
    dut.RandomAcessMemory.init_memory(8'(a + 8'd1), o1);
    dut.RandomAcessMemory.init_memory(8'(a + 8'd2), o2);
  endtask

  task automatic go();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2 rst = 1'b0;
    #1 rst = 1'b1;

    // program load: LDI A,2; LDI B,2; ADD A,B; HLT
    begin_load();
    ins(8'h00, 8'h01, 8'h00, 8'h02);
    ins(8'h03, 8'h01, 8'h01, 8'h02);
    ins(8'h06, 8'h03, 8'h00, 8'h01);
    ins(8'h09, 8'hFF, 8'h00, 8'h00);
    #1;
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_state", 32'(dut.state), 32'(FETCH_OP));
    chk("rst_flags", 32'(dut.flags), 32'h00);
    chk("rst_regA", 32'(dut.registers.read_memory(8'd0)), 32'h00);
    go();
    run(15);
    chk("prog_not_halted_15", 32'(halted), 32'h0);
    run(1);
    chk("prog_A", 32'(dut.registers.read_memory(8'd0)), 32'h04);
    chk("prog_B", 32'(dut.registers.read_memory(8'd1)), 32'h02);
    chk("prog_C", 32'(dut.registers.read_memory(8'd2)), 32'h00);
    chk("prog_halted", 32'(halted), 32'h1);
    chk("prog_pc", 32'(pc), 32'h0C);
    run(8);
    chk("halt_absorb_pc", 32'(pc), 32'h0C);
    chk("halt_absorb_halted", 32'(halted), 32'h1);
    chk("reg_upper_addr_ignored", 32'(dut.registers.read_memory(8'h08)), 32'h04);

    // flags + JEQ: 5-7 = 0xFE with borrow, then CMP equal, then taken jump
    begin_load();
    ins(8'h00, 8'h01, 8'h00, 8'h05);
    ins(8'h03, 8'h01, 8'h01, 8'h07);
    ins(8'h06, 8'h04, 8'h00, 8'h01);
    ins(8'h09, 8'h01, 8'h02, 8'hFE);
    ins(8'h0C, 8'h08, 8'h00, 8'h02);
    ins(8'h0F, 8'h0C, 8'h20, 8'h00);
    ins(8'h20, 8'hFF, 8'h00, 8'h00);
    go();
    run(12);
    chk("sub_A", 32'(dut.registers.read_memory(8'd0)), 32'hFE);
    chk("sub_flags", 32'(dut.flags), 32'h06);
    run(8);
    chk("cmp_flags", 32'(dut.flags), 32'h26);
    run(4);
    chk("jeq_taken_pc", 32'(pc), 32'h20);
    run(4);
    chk("jeq_target_hlt", 32'(halted), 32'h1);

    // same sequence with JNE: not taken
    begin_load();
    ins(8'h00, 8'h01, 8'h00, 8'h05);
    ins(8'h03, 8'h01, 8'h01, 8'h07);
    ins(8'h06, 8'h04, 8'h00, 8'h01);
    ins(8'h09, 8'h01, 8'h02, 8'hFE);
    ins(8'h0C, 8'h08, 8'h00, 8'h02);
    ins(8'h0F, 8'h0D, 8'h20, 8'h00);
    go();
    run(24);
    chk("jne_not_taken_pc", 32'(pc), 32'h12);

    // memory: LDI A,5A; ST A,[80]; LD B,[80]
    begin_load();
    ins(8'h00, 8'h01, 8'h00, 8'h5A);
    ins(8'h03, 8'h0A, 8'h00, 8'h80);
    ins(8'h06, 8'h09, 8'h01, 8'h80);
    go();
    run(8);
    chk("st_ram80", 32'(dut.RandomAcessMemory.mem[8'h80]), 32'h5A);
    run(4);
    chk("ld_B", 32'(dut.registers.read_memory(8'd1)), 32'h5A);

    // ADD A,A with signed overflow, then XOR clears C/V
    begin_load();
    ins(8'h00, 8'h01, 8'h00, 8'h80);
    ins(8'h03, 8'h03, 8'h00, 8'h00);
    ins(8'h06, 8'h01, 8'h01, 8'h81);
    ins(8'h09, 8'h07, 8'h00, 8'h01);
    go();
    run(8);
    chk("addAA_A", 32'(dut.registers.read_memory(8'd0)), 32'h00);
    chk("addAA_flags", 32'(dut.flags), 32'h0B);
    run(8);
    chk("xor_A", 32'(dut.registers.read_memory(8'd0)), 32'h81);
    chk("xor_flags", 32'(dut.flags), 32'h04);

    // reset asserted while EXEC of LDI A,33 is pending
    begin_load();
    ins(8'h00, 8'h01, 8'h00, 8'h33);
    go();
    run(3);
    chk("pre_rst_state", 32'(dut.state), 32'(EXEC));
    rst = 1'b0;
    #1;
    chk("midrst_pc", 32'(pc), 32'h00);
    chk("midrst_state", 32'(dut.state), 32'(FETCH_OP));
    run(2);
    chk("midrst_A", 32'(dut.registers.read_memory(8'd0)), 32'h00);
    chk("midrst_ram_kept", 32'(dut.RandomAcessMemory.mem[8'h02]), 32'h33);
    rst = 1'b1;

    // unknown opcode 0x42 behaves as NOP
    begin_load();
    ins(8'h00, 8'h01, 8'h00, 8'h11);
    ins(8'h03, 8'h08, 8'h00, 8'h00);
    ins(8'h06, 8'h42, 8'h01, 8'h02);
    go();
    run(12);
    chk("unk_pc", 32'(pc), 32'h09);
    chk("unk_A", 32'(dut.registers.read_memory(8'd0)), 32'h11);
    chk("unk_B", 32'(dut.registers.read_memory(8'd1)), 32'h00);
    chk("unk_flags", 32'(dut.flags), 32'h20);
    chk("unk_ram2", 32'(dut.RandomAcessMemory.mem[8'h02]), 32'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
